// File: rtl/mcycle_pkg.sv
// Shared types for the MCycle multiply/divide controller, datapath and bench.
package mcycle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ITER,
        FIXUP,
        DONE
    } stateT;

    localparam logic [1:0] OP_SMUL = 2'b00;
    localparam logic [1:0] OP_UMUL = 2'b01;
    localparam logic [1:0] OP_SDIV = 2'b10;
    localparam logic [1:0] OP_UDIV = 2'b11;

    // Division remainder takes the dividend's sign, so a negative
    // dividend alone still needs the fix-up cycle.
    function automatic logic fixNeeded(
        input logic isDiv,
        input logic neg1,
        input logic neg2
    );
        return isDiv ? ((neg1 ^ neg2) | neg1) : (neg1 ^ neg2);
    endfunction

endpackage

// File: rtl/mcycle_step_counter.sv
// Iteration counter for the MCycle controller.
// Flags the terminal step at WIDTH-1.
module mcycle_step_counter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mcycle_ctrl.sv
// Sequencer for the iterative multiply/divide datapath.
// Issues load, step and sign fix-up strobes; Busy stalls the pipeline.
module mcycle_ctrl
    import mcycle_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic             Sign1,
    input  logic             Sign2,
    input  logic             DivByZero,
    output logic             Busy,
    output logic             LoadOps,
    output logic             NegOp1,
    output logic             NegOp2,
    output logic             StepEn,
    output logic             IsDiv,
    output logic [CNT_W-1:0] Count,
    output logic             NegProd,
    output logic             NegQuot,
    output logic             NegRem,
    output logic             Done,
    output logic             DivZero
);

    stateT state;
    stateT nextState;

    logic isDivQ;
    logic neg1Q;
    logic neg2Q;
    logic dbzQ;
    logic cntClr;
    logic cntEn;
    logic cntLast;
    logic divZeroOp;

    assign divZeroOp = isDivQ & dbzQ;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state  <= IDLE;
            isDivQ <= 1'b0;
            neg1Q  <= 1'b0;
            neg2Q  <= 1'b0;
            dbzQ   <= 1'b0;
        end else begin
            state <= nextState;
            // Operands are only sampled with the accepted Start.
            if (state == IDLE && Start) begin
                isDivQ <= MCycleOp[1];
                neg1Q  <= ~MCycleOp[0] & Sign1;
                neg2Q  <= ~MCycleOp[0] & Sign2;
                dbzQ   <= DivByZero;
            end
        end
    end

    mcycle_step_counter #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) uCounter (
        .clk  (CLK),
        .rstN (RESETn),
        .clr  (cntClr),
        .en   (cntEn),
        .count(Count),
        .last (cntLast)
    );

    always_comb begin
        nextState = state;
        Busy      = 1'b0;
        LoadOps   = 1'b0;
        NegOp1    = 1'b0;
        NegOp2    = 1'b0;
        StepEn    = 1'b0;
        IsDiv     = 1'b0;
        NegProd   = 1'b0;
        NegQuot   = 1'b0;
        NegRem    = 1'b0;
        Done      = 1'b0;
        DivZero   = 1'b0;
        cntClr    = 1'b0;
        cntEn     = 1'b0;
        unique case (state)
            IDLE: begin
                Busy = Start;
                if (Start) nextState = LOAD;
            end
            LOAD: begin
                Busy    = 1'b1;
                LoadOps = 1'b1;
                NegOp1  = neg1Q;
                NegOp2  = neg2Q;
                cntClr  = 1'b1;
                nextState = divZeroOp ? DONE : ITER;
            end
            ITER: begin
                Busy   = 1'b1;
                StepEn = 1'b1;
                IsDiv  = isDivQ;
                cntEn  = 1'b1;
                if (cntLast) begin
                    nextState = fixNeeded(isDivQ, neg1Q, neg2Q)
                              ? FIXUP : DONE;
                end
            end
            FIXUP: begin
                Busy    = 1'b1;
                NegProd = ~isDivQ & (neg1Q ^ neg2Q);
                NegQuot = isDivQ & (neg1Q ^ neg2Q);
                NegRem  = isDivQ & neg1Q;
                nextState = DONE;
            end
            DONE: begin
                Done      = 1'b1;
                DivZero   = divZeroOp;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: schedule model plus directed latencies.
module tb_mcycle_ctrl;
    import mcycle_pkg::*;

    localparam int W  = 32;
    localparam int CW = $clog2(W);

    logic          CLK = 1'b0;
    logic          RESETn = 1'b0;
    logic          Start = 1'b0;
    logic [1:0]    MCycleOp = 2'b00;
    logic          Sign1 = 1'b0;
    logic          Sign2 = 1'b0;
    logic          DivByZero = 1'b0;
    logic          Busy, LoadOps, NegOp1, NegOp2, StepEn, IsDiv;
    logic [CW-1:0] Count;
    logic          NegProd, NegQuot, NegRem, Done, DivZero;

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;

    mcycle_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RESETn(RESETn), .Start(Start), .MCycleOp(MCycleOp),
        .Sign1(Sign1), .Sign2(Sign2), .DivByZero(DivByZero),
        .Busy(Busy), .LoadOps(LoadOps), .NegOp1(NegOp1), .NegOp2(NegOp2),
        .StepEn(StepEn), .IsDiv(IsDiv), .Count(Count),
        .NegProd(NegProd), .NegQuot(NegQuot), .NegRem(NegRem),
        .Done(Done), .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      name, act, exp, cyc);
    endtask

    // Model: an accepted op has a fixed schedule relative to its Start cycle.
    initial begin : model
        bit act;
        bit mNeg1, mNeg2, mDiv, mDz, fix, stepExp, fx;
        int t0, k, L;
        logic [10:0] exp, got;
        act = 0; t0 = 0; k = 0; L = 0;
        mNeg1 = 0; mNeg2 = 0; mDiv = 0; mDz = 0;
        forever begin
            @(negedge CLK);
            got = {Busy, LoadOps, NegOp1, NegOp2, StepEn, IsDiv,
                   NegProd, NegQuot, NegRem, Done, DivZero};
            exp = '0;
            if (act) begin
                k   = cyc - t0;
                fix = mDiv ? (mNeg1 | mNeg2) : (mNeg1 ^ mNeg2);
                L   = (mDiv && mDz) ? 2 : (fix ? W + 3 : W + 2);
            end
            if (!RESETn) begin
                act = 0;
                exp[10] = Start;
                check("resetCount", int'(Count), 0);
            end else if (!act) begin
                exp[10] = Start;
            end else begin
                stepExp = (k >= 2) && (k <= W + 1) && !(mDiv && mDz);
                fx = fix && (k == W + 2);
                exp[10] = (k < L);
                exp[9]  = (k == 1);
                exp[8]  = (k == 1) && mNeg1;
                exp[7]  = (k == 1) && mNeg2;
                exp[6]  = stepExp;
                exp[5]  = stepExp && mDiv;
                exp[4]  = fx && !mDiv;
                exp[3]  = fx && mDiv && (mNeg1 != mNeg2);
                exp[2]  = fx && mDiv && mNeg1;
                exp[1]  = (k == L);
                exp[0]  = (k == L) && mDiv && mDz;
                if (stepExp) check("count", int'(Count), k - 2);
            end
            check("outputs", int'(got), int'(exp));
            if (RESETn) begin
                if (act && k == L) begin
                    act = 0;
                end else if (!act && Start) begin
                    act   = 1;
                    t0    = cyc;
                    mDiv  = (MCycleOp == OP_SDIV) || (MCycleOp == OP_UDIV);
                    mNeg1 = (MCycleOp == OP_SMUL || MCycleOp == OP_SDIV) && Sign1;
                    mNeg2 = (MCycleOp == OP_SMUL || MCycleOp == OP_SDIV) && Sign2;
                    mDz   = DivByZero;
                end
            end
            cyc++;
        end
    end

    // Runs one op; operand inputs are scrambled after the Start cycle.
    task automatic runOp(input logic [1:0] op, input bit s1, input bit s2,
                         input bit dz, input bit hold, input int expDone,
                         input string name);
        int doneAt;
        int busyN;
        @(posedge CLK); #1;
        MCycleOp = op; Sign1 = s1; Sign2 = s2; DivByZero = dz; Start = 1'b1;
        doneAt = -1;
        busyN = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge CLK);
            if (Busy) busyN++;
            if (Done) begin
                doneAt = k;
                break;
            end
            @(posedge CLK); #1;
            if (!hold) Start = 1'b0;
            MCycleOp  = 2'($urandom);
            Sign1     = 1'($urandom);
            Sign2     = 1'($urandom);
            DivByZero = 1'($urandom);
        end
        check({name, "DoneCycle"}, doneAt, expDone);
        check({name, "BusyCycles"}, busyN, expDone);
    endtask

    initial begin : stim
        int seen;
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
        @(negedge CLK);
        check("idleBusy", int'(Busy), 0);

        runOp(OP_UMUL, 0, 0, 0, 1'b0, 34, "umul");
        runOp(OP_SMUL, 1, 0, 0, 1'b0, 35, "smulNeg1");
        runOp(OP_SDIV, 1, 1, 0, 1'b0, 35, "sdivNegBoth");
        runOp(OP_UDIV, 0, 0, 1, 1'b0, 2, "udivZero");
        runOp(OP_SDIV, 0, 1, 0, 1'b0, 35, "sdivNeg2");
        runOp(OP_SMUL, 1, 1, 0, 1'b0, 34, "smulNegBoth");
        runOp(OP_UDIV, 1, 1, 0, 1'b0, 34, "udivSigns");
        runOp(OP_SMUL, 0, 0, 1, 1'b0, 34, "smulDbzIgnored");
        runOp(OP_SDIV, 0, 1, 1, 1'b0, 2, "sdivZero");
        repeat (3) @(posedge CLK);

        runOp(OP_UMUL, 0, 0, 0, 1'b1, 34, "b2bFirst");
        runOp(OP_UMUL, 0, 0, 0, 1'b0, 34, "b2bSecond");
        repeat (2) @(posedge CLK);

        @(posedge CLK); #1;
        MCycleOp = OP_UMUL; Sign1 = 0; Sign2 = 0; DivByZero = 0; Start = 1'b1;
        @(posedge CLK); #1 Start = 1'b0;
        repeat (8) @(posedge CLK);
        @(negedge CLK);
        check("midIterCount", int'(Count), 7);
        @(posedge CLK); #1 RESETn = 1'b0;
        @(negedge CLK);
        check("rstBusy", int'(Busy), 0);
        check("rstStep", int'(StepEn), 0);
        check("rstCount", int'(Count), 0);
        repeat (2) @(posedge CLK);
        #1 RESETn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done || Busy) seen++;
        end
        check("postResetQuiet", seen, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/mcycle_ctrl.md
# mcycle_ctrl

Sequencing controller for the iterative multiply/divide (MCycle) datapath in the pipelined ARM core. It accepts a start request from the Execute stage and steps the shift-add/shift-subtract datapath through WIDTH iterations, plus an optional sign fix-up. It drives the `MCycleBusy` that the hazard unit uses to stall F/D/E and flush M. All datapath arithmetic stays outside this block; it only issues control strobes and status.

## Interface
Parameters:
- WIDTH, 32, operand width; number of iteration steps.
- CNT_W, $clog2(WIDTH), width of the step counter.

Ports:
- CLK  in  1  single clock; all state on rising edge.
- RESETn  in  1  asynchronous, active-low reset.
- Start  in  1  MCycle instruction valid in E stage (not flushed).
- MCycleOp  in  2  00 signed mul, 01 unsigned mul, 10 signed div, 11 unsigned div.
- Sign1  in  1  MSB of operand 1 (dividend/multiplicand).
- Sign2  in  1  MSB of operand 2 (divisor/multiplier).
- DivByZero  in  1  operand 2 == 0; sampled with Start.
- Busy  out  1  to hazard unit as `MCycleBusy`.
- LoadOps  out  1  datapath captures operands (abs values per NegOp1/NegOp2).
- NegOp1  out  1  negate operand 1 on load.
- NegOp2  out  1  negate operand 2 on load.
- StepEn  out  1  perform one iteration.
- IsDiv  out  1  iteration type: 1 shift-subtract, 0 shift-add.
- Count  out  CNT_W  current iteration index.
- NegProd  out  1  negate 2·WIDTH-bit product (fix-up).
- NegQuot  out  1  negate quotient (fix-up).
- NegRem  out  1  negate remainder (fix-up).
- Done  out  1  result valid this cycle; one-cycle pulse.
- DivZero  out  1  qualifies Done: datapath forces quotient all-ones, remainder = dividend.

## Operation
- States: IDLE, LOAD, ITER, FIXUP, DONE.
- IDLE: on Start, latch op, Sign1, Sign2, DivByZero; go to LOAD. Otherwise hold.
- Latched signed = ~op[0]; neg1 = signed & Sign1; neg2 = signed & Sign2.
- LOAD: LoadOps=1, NegOp1=neg1, NegOp2=neg2.
  - If div & DivByZero: go to DONE with DivZero.
  - Otherwise clear Count and go to ITER.
- ITER: StepEn=1, IsDiv=op[1]; Count increments each cycle.
  - At Count==WIDTH-1, go to FIXUP if a fix-up is needed, else DONE.
  - Fix-up is needed when mul: neg1^neg2; div: (neg1^neg2) | neg1.
- FIXUP: one cycle.
  - NegProd = ~op[1]&(neg1^neg2).
  - NegQuot = op[1]&(neg1^neg2).
  - NegRem = op[1]&neg1.
  - Then DONE.
- DONE: Done=1 (DivZero if applicable), Busy=0; always go to IDLE. Start is ignored in DONE, because the same instruction is still in E.
- Busy = (IDLE & Start) | LOAD | ITER | FIXUP. Busy is combinational so the stall applies in the Start cycle itself.
- Inputs other than Start are ignored outside IDLE; mid-operation operand changes have no effect.
- Reset (async, RESETn=0): state IDLE, Count=0, latches cleared, all outputs 0 except Busy, which follows Start combinationally in IDLE. Reset mid-operation abandons it; no Done is issued.

## Timing
- Start first seen in cycle 0 (IDLE) → LOAD in cycle 1 → ITER in cycles 2..WIDTH+1.
- No fix-up: Done at cycle WIDTH+2 (34 for WIDTH=32); Busy high in cycles 0..WIDTH+1.
- With fix-up: FIXUP at cycle WIDTH+2; Done at cycle WIDTH+3; Busy high in cycles 0..WIDTH+2.
- Divide by zero: Done at cycle 2; Busy high in cycles 0–1; no StepEn.
- The pipeline advances on the DONE edge. A new Start seen in the cycle after DONE (IDLE) begins a new operation with no idle gap.
- All strobes except Busy are registered-state decodes (Moore outputs); no input-to-output paths other than Start→Busy.

## Structure
- Shared package `mcycle_pkg`: state enum (IDLE, LOAD, ITER, FIXUP, DONE) and op encoding constants (OP_SMUL, OP_UMUL, OP_SDIV, OP_UDIV). Both are shared with the datapath and the bench.
- One sub-module, `mcycle_step_counter`: CNT_W-bit counter with clear, enable, and terminal flag at WIDTH-1.
- FSM, sign latches, and output decode live in `mcycle_ctrl`.

## Test plan
- Unsigned mul (op 01), Start held: Busy=1 in cycles 0–33; LoadOps in cycle 1; StepEn in cycles 2–33 with Count 0..31; Done=1, Busy=0 in cycle 34; no Neg* asserted.
- Signed mul (op 00), Sign1=1, Sign2=0: NegOp1=1, NegOp2=0 in cycle 1; NegProd=1 in cycle 34; Done in cycle 35; Busy=0 in cycle 35.
- Signed div (op 10), Sign1=1, Sign2=1: NegOp1=NegOp2=1 in LOAD; IsDiv=1 throughout ITER; FIXUP in cycle 34 with NegQuot=0, NegRem=1; Done in cycle 35.
- Unsigned div (op 11), DivByZero=1: LoadOps in cycle 1; Done=DivZero=1 in cycle 2; StepEn never asserted; Busy=1 only in cycles 0–1.
- Back-to-back ops: Start held high through DONE (cycle 34) produces no restart. A new Start in cycle 35 gives Busy=1 in cycle 35 and Done in cycle 69 (unsigned mul).
- RESETn driven low in cycle 10 (ITER): all outputs 0 immediately, Count=0; after release with Start=0, remains IDLE with no Done.
